// File: rtl/melody_pkg.sv
// Shared note encodings and helpers for the melody matcher.
// Notes are one-hot across C..B, with C in the MSB.
package melody_pkg;

  localparam int unsigned w_note = 12;

  typedef logic [w_note-1:0] note_t;

  localparam note_t no_note  = 12'b0000_0000_0000;
  localparam note_t note_c   = 12'b1000_0000_0000;
  localparam note_t note_cs  = 12'b0100_0000_0000;
  localparam note_t note_d   = 12'b0010_0000_0000;
  localparam note_t note_ds  = 12'b0001_0000_0000;
  localparam note_t note_e   = 12'b0000_1000_0000;
  localparam note_t note_f   = 12'b0000_0100_0000;
  localparam note_t note_fs  = 12'b0000_0010_0000;
  localparam note_t note_g   = 12'b0000_0001_0000;
  localparam note_t note_gs  = 12'b0000_0000_1000;
  localparam note_t note_a   = 12'b0000_0000_0100;
  localparam note_t note_as  = 12'b0000_0000_0010;
  localparam note_t note_b   = 12'b0000_0000_0001;

  localparam note_t note_df  = note_cs;
  localparam note_t note_ef  = note_ds;
  localparam note_t note_gf  = note_fs;
  localparam note_t note_af  = note_gs;
  localparam note_t note_bf  = note_as;

  // Step value marking a fully recognized melody at the default 4-bit state width.
  localparam logic [3:0] st_recognized = 4'hF;

  typedef enum logic [0:0] {StIdle, StScan} sched_state_e;

  function automatic logic is_onehot(note_t n);
    return (n != no_note) && ((n & (n - note_t'(1))) == no_note);
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational melody table: (melody, step) -> expected note and last-step flag.
// Steps past a melody's end, and unknown melodies, return no_note, which never matches.
module melody_rom
  import melody_pkg::*;
#(
  parameter int unsigned w_state = 4
) (
  input  logic [2:0]         melody,
  input  logic [w_state-1:0] step,
  output logic [w_note-1:0]  expected,
  output logic               last
);

  int len;

  always_comb begin
    expected = no_note;
    len      = 0;
    case (melody)
      3'd0: begin
        len = 5;
        case (int'(step))
          0:       expected = note_c;
          1:       expected = note_a;
          2:       expected = note_d;
          3:       expected = note_c;
          4:       expected = note_a;
          default: expected = no_note;
        endcase
      end
      3'd1: begin
        len = 9;
        case (int'(step))
          0:       expected = note_e;
          1:       expected = note_ef;
          2:       expected = note_e;
          3:       expected = note_ef;
          4:       expected = note_e;
          5:       expected = note_b;
          6:       expected = note_d;
          7:       expected = note_c;
          8:       expected = note_a;
          default: expected = no_note;
        endcase
      end
      3'd2: begin
        len = 12;
        case (int'(step))
          0:       expected = note_g;
          1:       expected = note_c;
          2:       expected = note_ef;
          3:       expected = note_d;
          4:       expected = note_c;
          5:       expected = note_ef;
          6:       expected = note_c;
          7:       expected = note_d;
          8:       expected = note_c;
          9:       expected = note_af;
          10:      expected = note_bf;
          11:      expected = note_g;
          default: expected = no_note;
        endcase
      end
      default: begin
        len      = 0;
        expected = no_note;
      end
    endcase
    last = (expected != no_note) && (int'(step) == len - 1);
  end

endmodule

// File: rtl/melody_match_scheduler.sv
// Scans all melody step counters through one shared ROM/comparator on each new note event.
// Define MELODY_TIMEOUT_EN to restart unfinished melodies after timeout_cycles idle cycles.
module melody_match_scheduler #(
  parameter int unsigned n_melodies     = 3,
  parameter int unsigned w_note         = 12,
  parameter int unsigned w_state        = 4,
  parameter int unsigned timeout_cycles = 100_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [w_note-1:0]             note,
  input  logic                          clear,
  output logic [n_melodies*w_state-1:0] states,
  output logic [n_melodies-1:0]         recognized,
  output logic                          busy,
  output logic                          scan_done,
  output logic                          event_overrun
);
  import melody_pkg::*;

  localparam int unsigned        iw       = (n_melodies > 1) ? $clog2(n_melodies) : 1;
  localparam logic [iw-1:0]      last_idx = iw'(n_melodies - 1);
  localparam logic [w_state-1:0] st_done  = '1;

  sched_state_e                  st_q;
  logic [iw-1:0]                 idx_q;
  logic [w_note-1:0]             last_note_q, cur_note_q, pend_note_q;
  logic                          pend_valid_q;
  logic [n_melodies*w_state-1:0] states_q;
  logic [n_melodies-1:0]         recognized_q;
  logic                          busy_q, scan_done_q, overrun_q;

  logic                          note_valid, note_event, match, rom_last;
  logic [w_state-1:0]            cur_state;
  logic [w_note-1:0]             rom_note;

  assign note_valid = is_onehot(note);
  assign note_event = note_valid && (note != last_note_q);
  assign cur_state  = states_q[idx_q*w_state +: w_state];
  // rom_note is zero past a melody's end, and cur_note_q is always one-hot.
  assign match      = (cur_state != st_done) && (rom_note == cur_note_q);

  melody_rom #(
    .w_state (w_state)
  ) u_rom (
    .melody   (3'(idx_q)),
    .step     (cur_state),
    .expected (rom_note),
    .last     (rom_last)
  );

`ifdef MELODY_TIMEOUT_EN
  logic [31:0] idle_cnt_q;
  logic        timed_out_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(timeout_cycles);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= StIdle;
      idx_q        <= '0;
      last_note_q  <= '0;
      cur_note_q   <= '0;
      pend_note_q  <= '0;
      pend_valid_q <= 1'b0;
      states_q     <= '0;
      recognized_q <= '0;
      busy_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef MELODY_TIMEOUT_EN
      idle_cnt_q   <= '0;
      timed_out_q  <= 1'b0;
`endif
    end else begin
      last_note_q <= note_valid ? note : '0;
      scan_done_q <= 1'b0;
      if (clear) begin
        st_q         <= StIdle;
        idx_q        <= '0;
        pend_valid_q <= 1'b0;
        states_q     <= '0;
        recognized_q <= '0;
        busy_q       <= 1'b0;
        overrun_q    <= 1'b0;
      end else begin
        unique case (st_q)
          StIdle: begin
            if (note_event) begin
              cur_note_q <= note;
              idx_q      <= '0;
              st_q       <= StScan;
              busy_q     <= 1'b1;
            end
          end
          StScan: begin
            if (match) begin
              if (rom_last) begin
                states_q[idx_q*w_state +: w_state] <= st_done;
                recognized_q[idx_q]                <= 1'b1;
              end else begin
                states_q[idx_q*w_state +: w_state] <= cur_state + w_state'(1);
              end
            end
            if (idx_q == last_idx) begin
              scan_done_q <= 1'b1;
              // An event on the final cycle passes straight through pending.
              if (note_event) begin
                cur_note_q   <= note;
                idx_q        <= '0;
                pend_valid_q <= 1'b0;
                if (pend_valid_q) overrun_q <= 1'b1;
              end else if (pend_valid_q) begin
                cur_note_q   <= pend_note_q;
                idx_q        <= '0;
                pend_valid_q <= 1'b0;
              end else begin
                st_q   <= StIdle;
                busy_q <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + iw'(1);
              if (note_event) begin
                pend_note_q  <= note;
                pend_valid_q <= 1'b1;
                if (pend_valid_q) overrun_q <= 1'b1;
              end
            end
          end
          default: st_q <= StIdle;
        endcase
      end
`ifdef MELODY_TIMEOUT_EN
      if (note_event && !clear) begin
        idle_cnt_q  <= '0;
        timed_out_q <= 1'b0;
      end else begin
        if (idle_cnt_q != 32'(timeout_cycles)) idle_cnt_q <= idle_cnt_q + 32'd1;
        if (!clear && !timed_out_q && (st_q == StIdle) &&
            (idle_cnt_q == 32'(timeout_cycles))) begin
          timed_out_q <= 1'b1;
          for (int unsigned k = 0; k < n_melodies; k++) begin
            if (states_q[k*w_state +: w_state] != st_done) states_q[k*w_state +: w_state] <= '0;
          end
        end
      end
`endif
    end
  end

  assign states        = states_q;
  assign recognized    = recognized_q;
  assign busy          = busy_q;
  assign scan_done     = scan_done_q;
  assign event_overrun = overrun_q;

endmodule
